// File: rtl/maverickOne_pkg.sv
// maverickOne_pkg: shared register-file sizing and scoreboard defaults
package maverickOne_pkg;
    localparam int NUM_REGS = 32;
    localparam int MEM_OUT_DEF = 4;
    typedef logic [$clog2(NUM_REGS)-1:0] reg_idx_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;
endpackage

// File: rtl/reg_scoreboard_lane.sv
// reg_scoreboard_lane: grant check for one issue lane, chained oldest-first
module reg_scoreboard_lane
    import maverickOne_pkg::*;
#(
    parameter int NR = NUM_REGS,
    parameter int CW = 3,
    parameter bit FIRST = 1'b0
) (
    input  logic [NR-1:0]         eff_locks,
    input  logic [CW-1:0]         mem_avail,
    input  logic                  prev_grant,
    input  logic                  stall,
    input  logic                  idle,
    input  logic                  valid,
    input  logic                  blocking,
    input  logic                  mem_op,
    input  logic [$clog2(NR)-1:0] rd,
    input  logic [NR-1:0]         reg_req,
    output logic                  grant,
    output logic [NR-1:0]         eff_locks_nxt,
    output logic [CW-1:0]         mem_avail_nxt
);
    logic [NR-1:0] rd_mask;
    assign rd_mask = (rd == '0) ? '0 : NR'(1) << rd;
    assign grant = valid && prev_grant && !stall
                && ((reg_req & eff_locks & ~NR'(1)) == '0)
                && ((eff_locks & rd_mask) == '0)
                && (!mem_op || mem_avail != '0)
                && (!blocking || (FIRST && idle));
    assign eff_locks_nxt = eff_locks | (grant ? rd_mask : '0);
    assign mem_avail_nxt = mem_avail - CW'(grant && mem_op);
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: multi-issue register lock scoreboard with memory credits and fence blocking
module reg_scoreboard
    import maverickOne_pkg::*;
#(
    parameter int NR = NUM_REGS,
    parameter int NI = 2,
    parameter int NW = 2,
    parameter int MEM_OUT = MEM_OUT_DEF,
    localparam int IW = $clog2(NR),
    localparam int CW = $clog2(MEM_OUT + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [NI-1:0]         pl_valid_i,
    input  logic [NI-1:0]         blocking_i,
    input  logic [NI-1:0][IW-1:0] rd_i,
    input  logic [NI-1:0][NR-1:0] reg_req_i,
    input  logic [NI-1:0]         mem_op_i,
    output logic [NI-1:0]         grant_o,
    input  logic [NW-1:0]         wb_valid_i,
    input  logic [NW-1:0][IW-1:0] wb_rd_i,
    input  logic                  mem_done_i,
    input  logic                  unblock_i,
    output logic [NR-1:0]         locks_o,
    output logic [CW-1:0]         mem_cnt_o,
    output logic                  mem_busy_o,
    output logic                  blocked_o
);
    logic [NR-1:0] locks_q, wb_mask, base;
    logic [CW-1:0] mem_cnt_q, mem_cnt_d, avail0;
    logic          block_q, stall, idle, dec, blk_grant;
    always_comb begin
        wb_mask = '0;
        for (int w = 0; w < NW; w++)
            if (wb_valid_i[w]) wb_mask[wb_rd_i[w]] = 1'b1;
    end
    assign base   = locks_q & ~wb_mask;
    assign stall  = flush_i || rst_i || block_q;
    assign idle   = (base == '0) && (mem_cnt_q == '0);
    assign avail0 = CW'(MEM_OUT) - mem_cnt_q;
    // each lane sees the locks and credits left over by the older lanes
    for (genvar g = 0; g < NI; g++) begin : lane_g
        logic [NR-1:0] eff_in, eff_out;
        logic [CW-1:0] avail_in, avail_out;
        logic          prev, grant;
        if (g == 0) begin : head
            assign eff_in   = base;
            assign avail_in = avail0;
            assign prev     = 1'b1;
        end else begin : tail
            assign eff_in   = lane_g[g-1].eff_out;
            assign avail_in = lane_g[g-1].avail_out;
            assign prev     = lane_g[g-1].grant;
        end
        reg_scoreboard_lane #(.NR(NR), .CW(CW), .FIRST(g == 0)) u_lane (
            .eff_locks     (eff_in),
            .mem_avail     (avail_in),
            .prev_grant    (prev),
            .stall         (stall),
            .idle          (idle),
            .valid         (pl_valid_i[g]),
            .blocking      (blocking_i[g]),
            .mem_op        (mem_op_i[g]),
            .rd            (rd_i[g]),
            .reg_req       (reg_req_i[g]),
            .grant         (grant),
            .eff_locks_nxt (eff_out),
            .mem_avail_nxt (avail_out)
        );
        assign grant_o[g] = grant;
    end
    assign dec       = mem_done_i && mem_cnt_q != '0;
    assign blk_grant = grant_o[0] && blocking_i[0];
    assign mem_cnt_d = mem_cnt_q + (avail0 - lane_g[NI-1].avail_out) - CW'(dec);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locks_q   <= '0;
            mem_cnt_q <= '0;
            block_q   <= 1'b0;
        end else begin
            locks_q   <= flush_i ? '0 : lane_g[NI-1].eff_out & ~NR'(1);
            mem_cnt_q <= mem_cnt_d;
            block_q   <= !flush_i && (blk_grant || (block_q && !unblock_i));
        end
    end
    assign locks_o    = block_q ? ~NR'(1) : locks_q;
    assign mem_cnt_o  = mem_cnt_q;
    assign mem_busy_o = mem_cnt_q == CW'(MEM_OUT);
    assign blocked_o  = block_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed and randomized checks against a behavioural scoreboard model
module tb_reg_scoreboard;
    logic            clk = 1'b0;
    logic            rst, flush, mem_done, unblock, mem_busy_o, blocked_o;
    logic [1:0]      pl_valid, blocking, mem_op, wb_valid, grant_o;
    logic [1:0][4:0] rd, wb_rd;
    logic [1:0][31:0] reg_req;
    logic [31:0]     locks_o;
    logic [2:0]      mem_cnt_o;
    logic [31:0]     m_locks = '0;
    int              m_cnt = 0;
    bit              m_blk = 1'b0;
    logic [1:0]      exp_g;
    int              checks = 0, fails = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .pl_valid_i(pl_valid),
        .blocking_i(blocking), .rd_i(rd), .reg_req_i(reg_req), .mem_op_i(mem_op),
        .grant_o(grant_o), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
        .mem_done_i(mem_done), .unblock_i(unblock), .locks_o(locks_o),
        .mem_cnt_o(mem_cnt_o), .mem_busy_o(mem_busy_o), .blocked_o(blocked_o)
    );

    function automatic logic [31:0] model_wb();
        logic [31:0] m = '0;
        for (int w = 0; w < 2; w++) if (wb_valid[w]) m[wb_rd[w]] = 1'b1;
        return m;
    endfunction

    function automatic logic [1:0] model_grant();
        logic [31:0] eff = m_locks & ~model_wb();
        int avail = 4 - m_cnt;
        logic [1:0] g = '0;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            ok = pl_valid[k] && !flush && !rst && !m_blk && (k == 0 || g[k-1] == 1'b1);
            if ((reg_req[k] & eff & 32'hFFFF_FFFE) != 0) ok = 0;
            if (rd[k] != 0 && eff[rd[k]]) ok = 0;
            if (mem_op[k] && avail <= 0) ok = 0;
            if (blocking[k] && (k != 0 || (m_locks & ~model_wb()) != 0 || m_cnt != 0)) ok = 0;
            if (ok) begin
                g[k] = 1'b1;
                if (rd[k] != 0) eff[rd[k]] = 1'b1;
                if (mem_op[k]) avail--;
            end
        end
        return g;
    endfunction

    function automatic logic [36:0] exp_state();
        return {m_blk ? 32'hFFFF_FFFE : m_locks, 3'(m_cnt), m_cnt == 4, m_blk};
    endfunction

    task automatic model_step();
        int dec = (mem_done && m_cnt > 0) ? 1 : 0;
        if (rst) begin
            m_locks = '0; m_cnt = 0; m_blk = 0;
        end else if (flush) begin
            m_locks = '0; m_blk = 0; m_cnt -= dec;
        end else begin
            m_locks &= ~model_wb();
            for (int k = 0; k < 2; k++)
                if (exp_g[k]) begin
                    if (rd[k] != 0) m_locks[rd[k]] = 1'b1;
                    if (mem_op[k]) m_cnt++;
                end
            m_locks[0] = 1'b0;
            m_cnt -= dec;
            if (exp_g[0] && blocking[0]) m_blk = 1;
            else if (unblock) m_blk = 0;
        end
    endtask

    task automatic clear();
        flush = 0; mem_done = 0; unblock = 0; pl_valid = '0; blocking = '0;
        mem_op = '0; wb_valid = '0; rd = '0; wb_rd = '0; reg_req = '0;
    endtask

    task automatic settle();
        #1;
        exp_g = model_grant();
    endtask

    task automatic tick();
        exp_g = model_grant();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear(); rst = 1; pl_valid = 2'b11;
        settle();
        checks++; if (grant_o !== 2'b00) begin fails++; $display("FAIL reset_grant: got %b want 00", grant_o); end
        tick(); tick();
        rst = 0; clear(); #1;
        checks++; if ({locks_o, mem_cnt_o, mem_busy_o, blocked_o} !== 37'd0) begin fails++; $display("FAIL reset_state: got %h want 0", {locks_o, mem_cnt_o, mem_busy_o, blocked_o}); end
        checks++; if (grant_o !== 2'b00) begin fails++; $display("FAIL reset_idle_grant: got %b want 00", grant_o); end
    endtask

    task automatic test_raw();
        clear(); pl_valid = 2'b11; rd[0] = 5; reg_req[1] = 32'h20;
        settle();
        checks++; if (grant_o !== 2'b01) begin fails++; $display("FAIL raw_grant: got %b want 01", grant_o); end
        tick();
        checks++; if (locks_o !== 32'h20) begin fails++; $display("FAIL raw_lock: got %h want 00000020", locks_o); end
        clear(); wb_valid[0] = 1; wb_rd[0] = 5; pl_valid = 2'b01; reg_req[0] = 32'h20; rd[0] = 5;
        settle();
        checks++; if (grant_o !== 2'b01) begin fails++; $display("FAIL raw_bypass_grant: got %b want 01", grant_o); end
        tick();
        checks++; if (locks_o !== 32'h20) begin fails++; $display("FAIL raw_set_wins: got %h want 00000020", locks_o); end
        clear(); wb_valid = 2'b11; wb_rd[0] = 5; wb_rd[1] = 5;
        tick();
        checks++; if (locks_o !== 32'h0) begin fails++; $display("FAIL raw_unlock: got %h want 0", locks_o); end
    endtask

    task automatic test_in_order_stall();
        clear(); pl_valid = 2'b01; rd[0] = 3;
        tick();
        clear(); pl_valid = 2'b11; reg_req[0] = 32'h8; rd[1] = 7;
        settle();
        checks++; if (grant_o !== 2'b00) begin fails++; $display("FAIL stall_grant: got %b want 00", grant_o); end
        tick();
        clear(); wb_valid[1] = 1; wb_rd[1] = 3;
        tick();
        checks++; if (locks_o !== 32'h0) begin fails++; $display("FAIL stall_unlock: got %h want 0", locks_o); end
    endtask

    task automatic test_mem_credits();
        clear(); pl_valid = 2'b11; mem_op = 2'b11;
        settle();
        checks++; if (grant_o !== 2'b11) begin fails++; $display("FAIL mem_grant1: got %b want 11", grant_o); end
        tick(); settle();
        checks++; if (grant_o !== 2'b11) begin fails++; $display("FAIL mem_grant2: got %b want 11", grant_o); end
        tick();
        checks++; if ({mem_cnt_o, mem_busy_o} !== {3'd4, 1'b1}) begin fails++; $display("FAIL mem_full: got cnt %0d busy %b want 4 1", mem_cnt_o, mem_busy_o); end
        settle();
        checks++; if (grant_o !== 2'b00) begin fails++; $display("FAIL mem_full_grant: got %b want 00", grant_o); end
        clear(); mem_done = 1;
        tick();
        checks++; if (mem_cnt_o !== 3'd3) begin fails++; $display("FAIL mem_done: got %0d want 3", mem_cnt_o); end
        clear(); pl_valid = 2'b11; mem_op = 2'b11;
        settle();
        checks++; if (grant_o !== 2'b01) begin fails++; $display("FAIL mem_one_credit: got %b want 01", grant_o); end
        tick();
        clear(); mem_done = 1;
        repeat (5) tick();
        checks++; if ({mem_cnt_o, mem_busy_o} !== 4'd0) begin fails++; $display("FAIL mem_drain: got cnt %0d busy %b want 0 0", mem_cnt_o, mem_busy_o); end
    endtask

    task automatic test_blocking();
        clear(); pl_valid = 2'b01; rd[0] = 9;
        tick();
        clear(); pl_valid = 2'b01; blocking[0] = 1;
        settle();
        checks++; if (grant_o !== 2'b00) begin fails++; $display("FAIL block_locked: got %b want 00", grant_o); end
        tick();
        wb_valid[0] = 1; wb_rd[0] = 9;
        settle();
        checks++; if (grant_o !== 2'b01) begin fails++; $display("FAIL block_grant: got %b want 01", grant_o); end
        tick();
        checks++; if ({locks_o, blocked_o} !== {32'hFFFF_FFFE, 1'b1}) begin fails++; $display("FAIL block_state: got %h %b want fffffffe 1", locks_o, blocked_o); end
        clear(); pl_valid = 2'b11;
        settle();
        checks++; if (grant_o !== 2'b00) begin fails++; $display("FAIL block_hold: got %b want 00", grant_o); end
        unblock = 1;
        tick();
        checks++; if ({locks_o, blocked_o} !== 33'd0) begin fails++; $display("FAIL unblock: got %h %b want 0 0", locks_o, blocked_o); end
        clear(); pl_valid = 2'b01; blocking[0] = 1; unblock = 1;
        tick();
        checks++; if (blocked_o !== 1'b1) begin fails++; $display("FAIL block_set_wins: got %b want 1", blocked_o); end
        clear(); unblock = 1;
        tick();
        checks++; if (blocked_o !== 1'b0) begin fails++; $display("FAIL block_release: got %b want 0", blocked_o); end
    endtask

    task automatic test_flush();
        clear(); pl_valid = 2'b11; blocking[0] = 1; rd[0] = 2; rd[1] = 5; mem_op = 2'b11;
        settle();
        checks++; if (grant_o !== 2'b11) begin fails++; $display("FAIL flush_setup_grant: got %b want 11", grant_o); end
        tick();
        checks++; if ({mem_cnt_o, blocked_o} !== {3'd2, 1'b1}) begin fails++; $display("FAIL flush_setup: got cnt %0d blk %b want 2 1", mem_cnt_o, blocked_o); end
        clear(); flush = 1; mem_done = 1; pl_valid = 2'b11;
        settle();
        checks++; if (grant_o !== 2'b00) begin fails++; $display("FAIL flush_grant: got %b want 00", grant_o); end
        tick();
        checks++; if ({locks_o, mem_cnt_o, blocked_o} !== {32'h0, 3'd1, 1'b0}) begin fails++; $display("FAIL flush_state: got %h %0d %b want 0 1 0", locks_o, mem_cnt_o, blocked_o); end
        clear(); mem_done = 1;
        tick();
        checks++; if ({locks_o, mem_cnt_o, mem_busy_o, blocked_o} !== exp_state()) begin fails++; $display("FAIL flush_drain: got %h want %h", {locks_o, mem_cnt_o, mem_busy_o, blocked_o}, exp_state()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            flush    = ($urandom_range(0, 31) == 0);
            mem_done = ($urandom_range(0, 2) == 0);
            unblock  = ($urandom_range(0, 3) == 0);
            pl_valid = 2'($urandom);
            mem_op   = 2'($urandom);
            wb_valid = 2'($urandom);
            for (int k = 0; k < 2; k++) begin
                blocking[k] = ($urandom_range(0, 7) == 0);
                rd[k]       = 5'($urandom_range(0, 7));
                wb_rd[k]    = 5'($urandom_range(0, 7));
                reg_req[k]  = $urandom_range(0, 1) ? (32'h1 << $urandom_range(0, 7)) : 32'h0;
            end
            settle();
            checks++; if (grant_o !== exp_g) begin fails++; $display("FAIL rand_grant[%0d]: got %b want %b", i, grant_o, exp_g); end
            tick();
            checks++; if ({locks_o, mem_cnt_o, mem_busy_o, blocked_o} !== exp_state()) begin fails++; $display("FAIL rand_state[%0d]: got %h want %h", i, {locks_o, mem_cnt_o, mem_busy_o, blocked_o}, exp_state()); end
        end
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_raw();
        test_in_order_stall();
        test_mem_credits();
        test_blocking();
        test_flush();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
